// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, sequences a fixed-length
// busy phase per operation, and produces the MD-hazard stall toward D.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     hi_n_q, hi_n_d, lo_n_q, lo_n_d;

    logic            is_signed;
    logic [63:0]     mul_a, mul_b, prod;
    logic            a_neg, b_neg, div_zero;
    logic [31:0]     a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    // Even opcodes (mult, div) are signed, odd ones (multu, divu) unsigned.
    assign is_signed = ~md_op[0];

    // Sign-extended 64-bit product truncated to 64 bits is exact for both signednesses.
    assign mul_a = {{32{is_signed & rs_val[31]}}, rs_val};
    assign mul_b = {{32{is_signed & rt_val[31]}}, rt_val};
    assign prod  = mul_a * mul_b;

    // Divide magnitudes and restore signs; this also makes 0x80000000 / -1
    // fall out as 0x80000000 rem 0 without a special case.
    assign a_neg    = is_signed & rs_val[31];
    assign b_neg    = is_signed & rt_val[31];
    assign a_mag    = a_neg ? (32'd0 - rs_val) : rs_val;
    assign b_mag    = b_neg ? (32'd0 - rt_val) : rt_val;
    assign div_zero = (rt_val == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign q_mag    = a_mag / b_safe;
    assign r_mag    = a_mag % b_safe;
    assign quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    // NOTE: every register, including the shadow result, is cleared by reset so an
    // aborted operation can never surface later as a stale HI/LO value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_n_q  <= '0;
            lo_n_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && md_op <= 3'd3) state_d = RUN;
            RUN:     if (cnt_q == CW'(1))        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        hi_n_d = hi_n_q;
        lo_n_d = lo_n_q;
        if (state_q == IDLE) begin
            if (start) begin
                case (md_op)
                    3'd0, 3'd1: begin
                        hi_n_d = prod[63:32];
                        lo_n_d = prod[31:0];
                        cnt_d  = CW'(MULT_CYCLES);
                    end
                    3'd2, 3'd3: begin
                        // Divide by zero commits the current HI/LO back, i.e. no change.
                        hi_n_d = div_zero ? hi_q : rem;
                        lo_n_d = div_zero ? lo_q : quot;
                        cnt_d  = CW'(DIV_CYCLES);
                    end
                    3'd4:    hi_d = rs_val;
                    3'd5:    lo_d = rs_val;
                    default: ;
                endcase
            end
        end else if (cnt_q == CW'(1)) begin
            hi_d  = hi_n_q;
            lo_d  = lo_n_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        busy     = (state_q == RUN);
        hi       = hi_q;
        lo       = lo_q;
        md_stall = d_is_md & (busy | (start & (md_op <= 3'd3)));
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, an arithmetic
// reference model compared on every falling edge, and literal expectations.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        d_is_md;
    logic        busy;
    logic [31:0] hi, lo;
    logic        md_stall;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .d_is_md (d_is_md),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles plus the result pending commit.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_rem = 0;
    bit          p_apply = 1'b0;

    always @(posedge clk) begin
        longint      sx, sy;
        logic [63:0] up;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0; p_apply = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && p_apply) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            sx = longint'($signed(rs_val));
            sy = longint'($signed(rt_val));
            case (md_op)
                3'd0: begin up = 64'(sx * sy); p_hi = up[63:32]; p_lo = up[31:0]; p_apply = 1; m_rem = 5; end
                3'd1: begin up = {32'd0, rs_val} * {32'd0, rt_val}; p_hi = up[63:32]; p_lo = up[31:0]; p_apply = 1; m_rem = 5; end
                3'd2: begin
                    p_apply = (rt_val != 0); m_rem = 10;
                    if (p_apply) begin p_lo = 32'(sx / sy); p_hi = 32'(sx % sy); end
                end
                3'd3: begin
                    p_apply = (rt_val != 0); m_rem = 10;
                    if (p_apply) begin p_lo = rs_val / rt_val; p_hi = rs_val % rt_val; end
                end
                3'd4: m_hi = rs_val;
                3'd5: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("model_busy", {31'd0, busy}, {31'd0, m_rem > 0});
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
            check("model_stall", {31'd0, md_stall},
                  {31'd0, d_is_md & ((m_rem > 0) | (start & (md_op <= 3'd3)))});
        end
    end

    // Callers are 2 time units after a rising edge; returns the same way.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(posedge clk); #2;
        end
        if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        issue(op, a, b);
        wait_idle(cyc);
        check({name, "_cycles"}, cyc, exp_cycles);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0; d_is_md = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        // Stall follows its inputs during reset; start is overridden by reset.
        d_is_md = 1'b1; start = 1'b1; md_op = 3'd2;
        #1 check("stall_in_reset", {31'd0, md_stall}, 32'd1);
        @(posedge clk); #2;
        check("reset_busy_over_start", {31'd0, busy}, 32'd0);
        reset = 1'b0; start = 1'b0; d_is_md = 1'b0;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        run_op("mult",  3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

        // Signed div with a D-stage MD instruction waiting behind it.
        d_is_md = 1'b1; start = 1'b1; md_op = 3'd2; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
        #1 check("stall_issue", {31'd0, md_stall}, 32'd1);
        @(posedge clk); #2;
        start = 1'b0;
        check("stall_busy", {31'd0, md_stall}, 32'd1);
        wait_idle(cyc);
        check("div_cycles", cyc, 10);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("stall_after", {31'd0, md_stall}, 32'd0);
        d_is_md = 1'b0;

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("divu",    3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("divu_z",  3'd3, 32'd55,  32'd0, 10, 32'd2, 32'd14);
        run_op("div_z",   3'd2, 32'hFFFF_FF00, 32'd0, 10, 32'd2, 32'd14);

        // Spurious starts mid-RUN must not disturb the result.
        issue(3'd0, 32'd3, 32'd5);
        @(posedge clk); #2;
        start = 1'b1; md_op = 3'd4; rs_val = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        md_op = 3'd0; rs_val = 32'd7; rt_val = 32'd7;
        @(posedge clk); #2;
        start = 1'b0;
        wait_idle(cyc);
        check("spur_cycles", cyc, 2);
        check("spur_hi", hi, 32'd0);
        check("spur_lo", lo, 32'd15);

        issue(3'd4, 32'h0000_1234, 32'd0);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h0000_ABCD, 32'd0);
        check("mtlo_lo", lo, 32'h0000_ABCD);
        check("mtlo_hi", hi, 32'h0000_1234);
        issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", hi, 32'h0000_1234);
        check("nop_lo", lo, 32'h0000_ABCD);

        // Reset on the 3rd busy cycle aborts the operation.
        issue(3'd0, 32'h0001_0000, 32'h0001_0000);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (6) begin @(posedge clk); #2; end
        check("abort_stale_hi", hi, 32'd0);
        run_op("mult_fresh", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12);

        // Back-to-back: issue in the first idle cycle after completion.
        run_op("b2b_1", 3'd1, 32'h8000_0000, 32'd4, 5, 32'd2, 32'd0);
        run_op("b2b_2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

        repeat (2) @(posedge clk);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
